// File: rtl/image_loader_pkg.sv
// Common classifier package: image geometry, pixel width and loader state type.
// IMG_LOADER_BINARIZE_EN selects 8-bit pixels binarized in the loader;
// without it pixels arrive as single bits.
package image_loader_pkg;

  // Image geometry shared with the classifier; image is indexed [row][col].
  localparam int LENGTH = 16;
  localparam int WIDTH  = 16;
  // Classifier window parameters, kept here so both sides agree on them.
  localparam int LEFT   = 0;
  localparam int SHIFT  = 1;

`ifdef IMG_LOADER_BINARIZE_EN
  localparam int PIX_W = 8;
`else
  localparam int PIX_W = 1;
`endif

  localparam int ROW_W = $clog2(LENGTH);
  localparam int COL_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FIRE = 2'd2,
    HOLD = 2'd3
  } loader_state_t;

endpackage

// File: rtl/image_loader_if.sv
// Pixel stream valid/ready interface between the pixel source and the loader.
// IMG_LOADER_BINARIZE_EN widens pix_data to 8 bits through the package.
interface image_loader_if;
  import image_loader_pkg::*;

  logic             pix_valid;
  logic             pix_ready;
  logic             pix_sof;
  logic [PIX_W-1:0] pix_data;

  modport master (output pix_valid, output pix_sof, output pix_data, input pix_ready);
  modport slave  (input pix_valid, input pix_sof, input pix_data, output pix_ready);

endinterface

// File: rtl/image_loader_raster_counter.sv
// Raster-order row/col position counter for the image loader.
// restart points at (0,1) because the start-of-frame beat itself lands on (0,0).
module raster_counter
  import image_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last
);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;

  // Next position: restart wins over a plain advance; col wraps into the next row.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (restart) begin
      row_d = '0;
      col_d = COL_W'(1);
    end else if (en) begin
      if (col_q == COL_W'(WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(LENGTH - 1)) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign last = (row_q == ROW_W'(LENGTH - 1)) && (col_q == COL_W'(WIDTH - 1));

endmodule

// File: rtl/image_loader.sv
// Image loader: assembles a LENGTH x WIDTH binary frame from a pixel stream
// and triggers one classification per completed frame via init_out.
// IMG_LOADER_BINARIZE_EN: 8-bit pixels stored as (pix_data >= THRESH).
//
//   state | meaning
//   IDLE  | waiting for a start-of-frame beat; other beats are dropped
//   LOAD  | filling the image in raster order; sof restarts the frame
//   FIRE  | image complete, init_out held low for one cycle
//   HOLD  | init_out high for HOLD_CYCLES cycles; frame_done on the last
module image_loader
  import image_loader_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
`ifdef IMG_LOADER_BINARIZE_EN
  ,
  parameter int THRESH = 128
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  image_loader_if.slave                pix,
  output logic [LENGTH-1:0][WIDTH-1:0] image,
  output logic                         init_out,
  output logic                         frame_done,
  output logic [15:0]                  frame_count,
  output logic [7:0]                   abort_count
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  loader_state_t               state_q, state_d;
  logic [HOLD_W-1:0]           hold_q, hold_d;
  logic [LENGTH-1:0][WIDTH-1:0] image_q, image_d;
  logic [15:0]                 frame_count_q, frame_count_d;
  logic [7:0]                  abort_count_q, abort_count_d;

  logic             accept;
  logic             pix_bit;
  logic             cnt_en;
  logic             cnt_restart;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             last;

`ifdef IMG_LOADER_BINARIZE_EN
  localparam logic [7:0] THRESH_B = 8'(THRESH);
  assign pix_bit = (pix.pix_data >= THRESH_B);
`else
  assign pix_bit = pix.pix_data[0];
`endif

  assign pix.pix_ready = !rst && ((state_q == IDLE) || (state_q == LOAD));
  assign accept        = pix.pix_valid && pix.pix_ready;

  raster_counter u_raster (
    .clk     (clk),
    .rst     (rst),
    .en      (cnt_en),
    .restart (cnt_restart),
    .row     (row),
    .col     (col),
    .last    (last)
  );

  // Next-state, image write and frame/abort bookkeeping.
  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    image_d       = image_q;
    frame_count_d = frame_count_q;
    abort_count_d = abort_count_q;
    cnt_en        = 1'b0;
    cnt_restart   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && pix.pix_sof) begin
          image_d[0][0] = pix_bit;
          cnt_restart   = 1'b1;
          state_d       = LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          if (pix.pix_sof) begin
            if (abort_count_q != 8'hFF) abort_count_d = abort_count_q + 8'd1;
            image_d[0][0] = pix_bit;
            cnt_restart   = 1'b1;
          end else begin
            image_d[row][col] = pix_bit;
            cnt_en            = 1'b1;
            if (last) state_d = FIRE;
          end
        end
      end
      FIRE: begin
        frame_count_d = frame_count_q + 16'd1;
        hold_d        = HOLD_W'(HOLD_CYCLES - 1);
        state_d       = HOLD;
      end
      HOLD: begin
        if (hold_q == '0) state_d = IDLE;
        else              hold_d  = hold_q - HOLD_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      hold_q        <= '0;
      image_q       <= '0;
      frame_count_q <= '0;
      abort_count_q <= '0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      image_q       <= image_d;
      frame_count_q <= frame_count_d;
      abort_count_q <= abort_count_d;
    end
  end

  assign image       = image_q;
  assign init_out    = (state_q == HOLD);
  assign frame_done  = (state_q == HOLD) && (hold_q == '0);
  assign frame_count = frame_count_q;
  assign abort_count = abort_count_q;

endmodule

// File: tb/tb_image_loader.sv
// Randomized bench for image_loader against a raster-position reference model.
module tb_image_loader;
  import image_loader_pkg::*;

  localparam int HOLD = 4;
  localparam int NPIX = LENGTH * WIDTH;
  localparam int CW   = (NPIX > 16) ? NPIX : 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  image_loader_if pix_if ();

  logic [LENGTH-1:0][WIDTH-1:0] image;
  logic        init_out;
  logic        frame_done;
  logic [15:0] frame_count;
  logic [7:0]  abort_count;
  logic [NPIX-1:0] img_flat;
  assign img_flat = image;

  image_loader #(.HOLD_CYCLES(HOLD)) dut (
    .clk         (clk),
    .rst         (rst),
    .pix         (pix_if.slave),
    .image       (image),
    .init_out    (init_out),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .abort_count (abort_count)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pixel p of a frame goes to raster position p = row*WIDTH+col.
  bit          exp_img [NPIX];
  int          m_pos;
  bit          m_active;
  logic [15:0] exp_frames;
  logic [7:0]  exp_aborts;

  task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] exp_flat();
    logic [CW-1:0] v;
    v = '0;
    for (int p = 0; p < NPIX; p++) v[p] = exp_img[p];
    return v;
  endfunction

  function automatic bit model_bit(input logic [PIX_W-1:0] d);
`ifdef IMG_LOADER_BINARIZE_EN
    return (d >= 8'd128);
`else
    return d[0];
`endif
  endfunction

  function automatic void model_reset();
    for (int p = 0; p < NPIX; p++) exp_img[p] = 1'b0;
    m_pos      = 0;
    m_active   = 1'b0;
    exp_frames = '0;
    exp_aborts = '0;
  endfunction

  function automatic void model_accept(input bit sof, input logic [PIX_W-1:0] d);
    if (!sof && !m_active) return;
    if (sof) begin
      if (m_active && exp_aborts != 8'd255) exp_aborts = exp_aborts + 8'd1;
      m_active = 1'b1;
      m_pos    = 0;
    end
    exp_img[m_pos] = model_bit(d);
    m_pos++;
    if (m_pos == NPIX) begin
      m_active   = 1'b0;
      exp_frames = exp_frames + 16'd1;
    end
  endfunction

  // Offer one beat until accepted (bounded); returns at posedge+1 after acceptance.
  task automatic put_beat(input bit sof, input logic [PIX_W-1:0] d);
    bit acc;
    int t;
    acc = 1'b0;
    t   = 0;
    pix_if.pix_valid = 1'b1;
    pix_if.pix_sof   = sof;
    pix_if.pix_data  = d;
    while (!acc && t < 50) begin
      @(negedge clk);
      if (pix_if.pix_ready) acc = 1'b1;
      @(posedge clk);
      #1;
      t++;
    end
    chk("beat_accept", CW'(acc), CW'(1));
    if (acc) model_accept(sof, d);
  endtask

  task automatic idle_cycle();
    pix_if.pix_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // pat: 0 corners set, 1 random, 2 values 127/128/255 repeating.
  // gap: 0 contiguous, 1 valid toggling, 2 random idle cycles.
  task automatic send_frame(input int n, input int pat, input int gap, input bit hold_valid);
    logic [7:0]       bz [3];
    logic [PIX_W-1:0] d;
    bz[0] = 8'd127;
    bz[1] = 8'd128;
    bz[2] = 8'd255;
    for (int i = 0; i < n; i++) begin
      case (pat)
        0:       d = (i == 0 || i == NPIX - 1) ? '1 : '0;
        1:       d = PIX_W'($urandom);
        default: d = PIX_W'(bz[i % 3]);
      endcase
      if (gap == 1 && i > 0) idle_cycle();
      if (gap == 2) begin
        int g;
        g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) idle_cycle();
      end
      put_beat(i == 0, d);
    end
    pix_if.pix_valid = hold_valid;
    pix_if.pix_sof   = 1'b0;
  endtask

  // Checks the cycles after the last accepted beat: k=1 FIRE, k=2..HOLD+1 HOLD, k=HOLD+2 IDLE.
  task automatic check_tail(input int last_k);
    logic [CW-1:0] img_at_fire;
    img_at_fire = exp_flat();
    for (int k = 1; k <= last_k; k++) begin
      @(negedge clk);
      chk($sformatf("init_out_k%0d", k), CW'(init_out), CW'((k >= 2 && k <= HOLD + 1) ? 1 : 0));
      chk($sformatf("frame_done_k%0d", k), CW'(frame_done), CW'((k == HOLD + 1) ? 1 : 0));
      chk($sformatf("pix_ready_k%0d", k), CW'(pix_if.pix_ready), CW'((k == HOLD + 2) ? 1 : 0));
      chk($sformatf("image_k%0d", k), CW'(img_flat), img_at_fire);
      if (k == 1) chk("frame_count_fire", CW'(frame_count), CW'(exp_frames - 16'd1));
      else        chk("frame_count_hold", CW'(frame_count), CW'(exp_frames));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_state(input string tag);
    @(negedge clk);
    chk({tag, "_image"}, CW'(img_flat), exp_flat());
    chk({tag, "_frames"}, CW'(frame_count), CW'(exp_frames));
    chk({tag, "_aborts"}, CW'(abort_count), CW'(exp_aborts));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst              = 1'b1;
    pix_if.pix_valid = 1'b1;
    pix_if.pix_sof   = 1'b1;
    pix_if.pix_data  = '1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_ready", CW'(pix_if.pix_ready), CW'(0));
    chk("rst_init", CW'(init_out), CW'(0));
    chk("rst_done", CW'(frame_done), CW'(0));
    chk("rst_image", CW'(img_flat), CW'(0));
    chk("rst_frames", CW'(frame_count), CW'(0));
    chk("rst_aborts", CW'(abort_count), CW'(0));
    pix_if.pix_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", CW'(pix_if.pix_ready), CW'(1));
    @(posedge clk);
    #1;

    // Contiguous frame, only the two corners set.
    send_frame(NPIX, 0, 0, 1'b0);
    check_tail(HOLD + 2);
    check_state("corners");

    // Valid held through FIRE/HOLD, then stray non-sof beats are dropped in IDLE.
    send_frame(NPIX, 1, 0, 1'b1);
    check_tail(HOLD + 2);
    for (int i = 0; i < 5; i++) put_beat(1'b0, PIX_W'($urandom));
    pix_if.pix_valid = 1'b0;
    check_state("held_valid");

    // Frame restarted by sof at beat 100, then a complete frame.
    send_frame(100, 1, 2, 1'b0);
    check_state("partial");
    send_frame(NPIX, 1, 0, 1'b0);
    check_tail(HOLD + 2);
    check_state("abort");

    // Valid toggling every cycle.
    send_frame(NPIX, 1, 1, 1'b0);
    check_tail(HOLD + 2);
    check_state("toggle");

    // Reset during the second HOLD cycle.
    send_frame(NPIX, 1, 2, 1'b0);
    check_tail(2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    @(negedge clk);
    chk("midrst_init", CW'(init_out), CW'(0));
    chk("midrst_ready", CW'(pix_if.pix_ready), CW'(0));
    chk("midrst_frames", CW'(frame_count), CW'(0));
    chk("midrst_image", CW'(img_flat), CW'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_ready", CW'(pix_if.pix_ready), CW'(1));
    @(posedge clk);
    #1;
    send_frame(NPIX, 1, 2, 1'b0);
    check_tail(HOLD + 2);
    check_state("after_rst");

    // Threshold boundary values 127/128/255.
    send_frame(NPIX, 2, 0, 1'b0);
    check_tail(HOLD + 2);
    check_state("thresh");
`ifdef IMG_LOADER_BINARIZE_EN
    chk("bin_127", CW'(image[0][0]), CW'(0));
    chk("bin_128", CW'(image[0][1]), CW'(1));
    chk("bin_255", CW'(image[0][2]), CW'(1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/image_loader.md
Name: image_loader

Overview:
- Producer side of the classifier's image/init interface.
- Accepts a raster-ordered pixel stream with a valid/ready handshake and assembles a full LENGTH x WIDTH binary image.
- Presents the image stable to the classifier, then raises init_out to start one classification per frame.
- Sits between the pixel source (UART/camera front end) and the classifier.

Parameters:
- LENGTH, from package, number of rows (image first index).
- WIDTH, from package, number of columns (second index); must be >= 2.
- HOLD_CYCLES, 4, cycles init_out stays high per frame; must be >= 1.
- THRESH, 128, binarization threshold (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- pix_valid  in  1  source has a pixel.
- pix_ready  out  1  loader can accept a pixel.
- pix_sof  in  1  qualifies the beat as the first pixel of a frame, at (row 0, col 0).
- pix_data  in  PIX_W  pixel value; PIX_W=1, or 8 with the optional feature.
- image  out  [LENGTH-1:0][WIDTH-1:0]  assembled frame, indexed image[row][col].
- init_out  out  1  classification trigger; one rising edge per completed frame.
- frame_done  out  1  one-cycle pulse in the last HOLD cycle.
- frame_count  out  16  completed frames; wraps.
- abort_count  out  8  frames restarted by a mid-frame sof; saturates at 255.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset state: IDLE, with image=0, init_out=0, frame_done=0, frame_count=0, abort_count=0, row=0, col=0. pix_ready=0 while rst is high.
- A beat is accepted when pix_valid and pix_ready are both high in the same cycle.
- pix_ready is a combinational decode of the registered state: 1 in IDLE and LOAD, 0 in FIRE and HOLD.
- Pixel bit: pix_data[0] when PIX_W=1.
- IDLE:
  - An accepted beat with pix_sof=0 is dropped; no state change.
  - An accepted beat with pix_sof=1 writes image[0][0], sets col=1, row=0 and moves to LOAD.
- LOAD:
  - An accepted beat with pix_sof=0 writes image[row][col].
  - col increments. At col=WIDTH-1 it wraps to 0 and row increments.
  - An accepted beat with pix_sof=1 aborts the frame: abort_count increments (saturating), the beat is written to image[0][0], and the counters restart at row=0, col=1. Stale pixels are overwritten later; they are never cleared.
  - Accepting the pixel at (LENGTH-1, WIDTH-1) moves to FIRE.
  - A cycle with no accepted beat holds all state.
- FIRE (1 cycle):
  - image stable, init_out=0. This guarantees a low-to-high edge even if frames run back to back.
  - Then moves to HOLD, and frame_count increments on that transition.
- HOLD:
  - init_out=1 for exactly HOLD_CYCLES cycles, counted by a hold counter.
  - frame_done=1 in the final HOLD cycle.
  - Then moves to IDLE with init_out=0.
- Latency: last pixel accepted in cycle N. FIRE is in N+1. init_out is high in N+2 .. N+1+HOLD_CYCLES. pix_ready returns in N+2+HOLD_CYCLES.
- image is modified only in IDLE/LOAD on accepted beats. It is constant throughout FIRE and HOLD.
- Reset mid-operation, in any state: next cycle is IDLE with all reset values; a partial frame is discarded.
- Row/col counters are $clog2(LENGTH) and $clog2(WIDTH) bits and never exceed LENGTH-1 / WIDTH-1.

Optional Feature:
- Macro: IMG_LOADER_BINARIZE_EN.
- When defined: PIX_W=8, and the stored bit is (pix_data >= THRESH) as an unsigned compare.
- When undefined: PIX_W=1, the stored bit is pix_data[0], and THRESH is unused.
- Handshake and timing are identical in both builds.

Decomposition:
- Existing common package (holds LENGTH, WIDTH, LEFT, SHIFT): add PIX_W (conditional on the macro) and the typedef loader_state_t {IDLE, LOAD, FIRE, HOLD}.
- One sub-module, raster_counter:
  - Row/col counter with enable, restart and wrap.
  - Outputs row, col and a last flag, where last = (row==LENGTH-1 && col==WIDTH-1).

Test Plan:
- Reset, then sof plus LENGTH*WIDTH contiguous beats, all 0 except (0,0)=1 and (LENGTH-1,WIDTH-1)=1 -> image matches. init_out high exactly 4 cycles starting 2 cycles after the last beat. frame_count=1. frame_done pulses once.
- pix_valid held high through FIRE/HOLD with pix_sof=0 -> pix_ready=0, image unchanged. Beats after return to IDLE are dropped until a sof beat arrives.
- sof reasserted at beat 100 of a frame, then a full frame -> abort_count=1, frame_count=1, image equals the second frame only.
- pix_valid toggling every cycle over a full frame -> same image and same init_out shape as the contiguous case.
- rst asserted during the 2nd HOLD cycle -> init_out=0, frame_count=0, state IDLE on the next cycle. A following full frame completes normally.
- With IMG_LOADER_BINARIZE_EN, pixel values 127/128/255 -> stored bits 0/1/1.
